// File: rtl/uart8_transmitter.sv
// uart8_transmitter
//
// 8-bit UART transmitter. Accepts a byte over a valid/ready handshake and
// serialises it as one start bit (low), eight data bits LSB first, an
// optional even-parity bit and STOP_BITS stop bits (high). Every bit is held
// for CLKS_PER_BIT clocks of the 16x baud clock.
//
// Optional feature: define UART_TX_PARITY_EN to insert one even-parity bit
// (XOR of the data bits) after data bit 7. Without it the PARITY state and
// the parity register do not exist and the frame is one bit shorter.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (>= 2)
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports:
//   clk      16x baud clock, rising edge
//   rst      asynchronous, active-high reset
//   en       block enable; low aborts any frame and holds the block idle
//   data_in  byte to send, sampled only on acceptance
//   valid    data_in is valid; held until accepted
//   ready    high only while idle with en=1; valid&ready accepts the byte
//   tx       serial line, idles high
//   busy     high from the cycle after acceptance until the frame ends
//   done     one-cycle pulse on the last clock of the final stop bit
//
// All outputs are registered: the next-state logic computes the next value
// of every output from the next state, so no input reaches an output
// combinationally.

module uart8_transmitter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  // The stop counter only needs to tell the first of two stop bits from the last.
  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP_BIT  = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic          stop_cnt, stop_cnt_n;
  logic [7:0]    shift_reg, shift_n;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit, parity_n;
`endif
  logic          tx_n, ready_n, busy_n, done_n;
  logic          bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      shift_reg  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
      tx         <= 1'b1;
      ready      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      clk_cnt    <= clk_cnt_n;
      bit_idx    <= bit_idx_n;
      stop_cnt   <= stop_cnt_n;
      shift_reg  <= shift_n;
`ifdef UART_TX_PARITY_EN
      parity_bit <= parity_n;
`endif
      tx         <= tx_n;
      ready      <= ready_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    clk_cnt_n  = clk_cnt;
    bit_idx_n  = bit_idx;
    stop_cnt_n = stop_cnt;
    shift_n    = shift_reg;
`ifdef UART_TX_PARITY_EN
    parity_n   = parity_bit;
`endif
    tx_n       = 1'b1;
    ready_n    = 1'b0;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    bit_end    = (clk_cnt == CNT_LAST);

    if (!en) begin
      // Abort: the byte in flight is dropped and no done pulse is produced.
      state_n    = IDLE;
      clk_cnt_n  = '0;
      bit_idx_n  = '0;
      stop_cnt_n = 1'b0;
    end else begin
      // Inside a frame the bit-time counter free-runs and wraps at the bit end.
      if (state != IDLE) begin
        clk_cnt_n = bit_end ? '0 : clk_cnt + CW'(1);
      end

      case (state)
        IDLE: begin
          if (valid && ready) begin
            shift_n   = data_in;
`ifdef UART_TX_PARITY_EN
            parity_n  = ^data_in;
`endif
            clk_cnt_n = '0;
            state_n   = START_BIT;
          end
        end
        START_BIT: begin
          if (bit_end) state_n = DATA_BITS;
        end
        DATA_BITS: begin
          if (bit_end) begin
            // 7 -> 0 wrap leaves the index ready for the next frame.
            bit_idx_n = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP_BIT;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) state_n = STOP_BIT;
        end
`endif
        STOP_BIT: begin
          if (bit_end) begin
            if (stop_cnt == STOP_LAST) begin
              stop_cnt_n = 1'b0;
              state_n    = IDLE;
            end else begin
              stop_cnt_n = 1'b1;
            end
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end

    // Registered outputs are decoded from where the FSM will be next cycle.
    case (state_n)
      START_BIT: tx_n = 1'b0;
      DATA_BITS: tx_n = shift_n[bit_idx_n];
`ifdef UART_TX_PARITY_EN
      PARITY:    tx_n = parity_n;
`endif
      default:   tx_n = 1'b1;
    endcase

    busy_n  = (state_n != IDLE);
    ready_n = en && (state_n == IDLE);
    done_n  = (state_n == STOP_BIT) && (clk_cnt_n == CNT_LAST) &&
              (stop_cnt_n == STOP_LAST);
  end

endmodule
